hack_run_controller: RTL
========================

# hack_run_controller

Run controller for the Hack CPU. It loads a program into instruction ROM over a valid/ready stream while holding the CPU in reset. It then issues one clean reset cycle and gates the CPU clock enable to provide halt, run, single-step and PC breakpoint control. It sits between the host/debug interface and the CPU + instruction ROM.

## Interface
Parameters:
- ROM_AW, 15, instruction ROM address width (matches Hack PC width)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; forces LOAD state
- ld_valid  in  1  load word valid
- ld_ready  out  1  controller accepts a load word
- ld_data  in  16  instruction word
- ld_last  in  1  marks final word of program
- cmd_load  in  1  pulse: abandon execution, restart program load
- cmd_run  in  1  pulse: free-run from HALT
- cmd_halt  in  1  pulse: stop from RUN
- cmd_step  in  1  pulse: execute exactly one instruction from HALT
- bp_en  in  1  breakpoint enable
- bp_addr  in  ROM_AW  breakpoint PC
- cpu_pc  in  ROM_AW  current CPU PC
- cpu_reset  out  1  CPU reset
- cpu_clk_en  out  1  CPU clock enable; CPU state updates only when 1
- rom_we  out  1  ROM write strobe
- rom_addr  out  ROM_AW  ROM write address
- rom_wdata  out  16  ROM write data
- halted  out  1  state is HALT
- bp_hit  out  1  sticky: last halt was caused by breakpoint
- ld_wrap  out  1  sticky: load address wrapped past 2^ROM_AW-1

## Operation
States are LOAD, RSTCYC, HALT, RUN and STEP. Reset value of the state register is LOAD.

- **LOAD**
  - Outputs: cpu_reset=1, cpu_clk_en=0, ld_ready=1.
  - On handshake (ld_valid&ld_ready): rom_we=1, rom_addr=load counter, rom_wdata=ld_data, all combinational in the same cycle. The counter then increments.
  - Counter wraps modulo 2^ROM_AW. A wrap sets ld_wrap; loading continues.
  - A handshake with ld_last=1 goes to RSTCYC.
- **RSTCYC** (one cycle): cpu_reset=1 and cpu_clk_en=1, so the CPU's synchronous PC reset takes effect. Then go to HALT.
- **HALT**
  - Outputs: cpu_reset=0, cpu_clk_en=0.
  - cmd_step goes to STEP. cmd_run goes to RUN and clears bp_hit.
  - cmd_halt is ignored.
- **STEP**: cpu_clk_en=1 for exactly one cycle, then HALT. Breakpoint is not checked.
- **RUN**
  - cpu_clk_en = !(bp_en && armed && cpu_pc==bp_addr). This is combinational, so the breakpoint instruction is not executed.
  - A breakpoint match goes to HALT and sets bp_hit.
  - cmd_halt goes to HALT; cpu_clk_en=1 still applies in the cycle cmd_halt is sampled.
- **armed flag**
  - Cleared on entry to RUN.
  - Set after the first RUN cycle, so resuming from a breakpoint executes that instruction.
- **cmd_load** from any state except LOAD goes to LOAD, clears the load counter, ld_wrap and bp_hit.
- **Command priority** when several commands are set together: cmd_load > cmd_halt > cmd_step > cmd_run. Commands not valid in the current state are ignored.

## Timing
- **Outputs during reset:** state=LOAD, counter=0, cpu_reset=1, cpu_clk_en=0, rom_we=0, halted=0, bp_hit=0, ld_wrap=0.
- **ld_ready:**
  - 0 while reset is asserted.
  - 1 from the first clk edge after reset deasserts, while in LOAD.
  - Drops to 0 in the cycle after the ld_last handshake.
- **Load throughput:** one word per cycle.
- **ld_last to run:** with back-to-back words, the ld_last handshake in cycle N gives RSTCYC in N+1 and HALT in N+2. cmd_run sampled in N+2 gives RUN with cpu_clk_en=1 in N+3.
- **Command latency:** every cmd_* is sampled on a clk edge and takes effect on outputs one cycle later. Exception: the breakpoint gating of cpu_clk_en, which is same-cycle.
- **cmd_step held high:** each HALT→STEP→HALT round trip takes 2 cycles, so one instruction executes per 2 cycles.
- **Reset mid-operation:** asynchronous return to LOAD with reset values. A partially loaded program must be reloaded.

## Test plan
- **Load and release:** reset pulse, then 4 words 0x0002, 0xEC10, 0x0003, 0xE308 with ld_last on the 4th.
  - Required: rom_we at addresses 0..3 with matching data; RSTCYC shows cpu_reset=1 & cpu_clk_en=1 for exactly 1 cycle; then halted=1 and ld_ready=0.
- **Single step:** from HALT, three cmd_step pulses spaced 3 cycles apart.
  - Required: exactly 3 cycles with cpu_clk_en=1; halted returns to 1 after each.
- **Breakpoint:** bp_en=1, bp_addr=5, cmd_run, CPU counts PC 0,1,2,...
  - Required: cpu_clk_en=0 in the cycle cpu_pc=5; then HALT and bp_hit=1.
  - Then cmd_run: cpu_clk_en=1 with cpu_pc=5 on the first RUN cycle; bp_hit cleared.
- **Command priority:** in RUN, assert cmd_halt and cmd_run together → HALT. In HALT, assert cmd_step and cmd_run together → STEP, then HALT.
- **Wrap and reload:** ROM_AW=3, 9 words, last on the 9th.
  - Required: 9th word written at address 0 and ld_wrap=1.
  - Then cmd_load from HALT: cpu_reset=1, counter=0, ld_wrap=0.
- **Async reset mid-run:** assert reset between clock edges during RUN.
  - Required: cpu_reset=1 and cpu_clk_en=0 immediately, before the next edge; bp_hit=0.

Source files
------------

// File: rtl/hack_run_controller.sv
// hack_run_controller: loads a program into instruction ROM while the CPU is
// held in reset, issues one CPU reset cycle, then gates the CPU clock enable
// for halt / run / single-step / PC-breakpoint control.
module hack_run_controller #(
   parameter int ROM_AW = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [15:0]       ld_data,
   input  logic              ld_last,
   input  logic              cmd_load,
   input  logic              cmd_run,
   input  logic              cmd_halt,
   input  logic              cmd_step,
   input  logic              bp_en,
   input  logic [ROM_AW-1:0] bp_addr,
   input  logic [ROM_AW-1:0] cpu_pc,
   output logic              cpu_reset,
   output logic              cpu_clk_en,
   output logic              rom_we,
   output logic [ROM_AW-1:0] rom_addr,
   output logic [15:0]       rom_wdata,
   output logic              halted,
   output logic              bp_hit,
   output logic              ld_wrap
);

   typedef enum logic [2:0] {
      S_LOAD,
      S_RSTCYC,
      S_HALT,
      S_RUN,
      S_STEP
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [ROM_AW-1:0] ld_cnt;
   logic              armed;
   logic              ready_q;
   logic              cpu_reset_q;
   logic              halted_q;
   logic              handshake;
   logic              bp_match;

   // ready_q is only ever 1 while in LOAD, so it alone qualifies the handshake
   assign handshake = ld_valid & ready_q;
   // armed stays low during the first RUN cycle so a resume from a breakpoint
   // executes the instruction sitting at the breakpoint address
   assign bp_match  = bp_en & armed & (cpu_pc == bp_addr);

   assign ld_ready  = ready_q;
   assign cpu_reset = cpu_reset_q;
   assign halted    = halted_q;
   assign rom_we    = handshake;
   assign rom_addr  = ld_cnt;
   assign rom_wdata = ld_data;

   // Next-state selection; command priority is load > halt > step > run,
   // and commands that do not apply in the current state fall through.
   always_comb begin
      // NOTE: default assignment first so every path drives next_state and no latch is inferred.
      next_state = state;
      unique case (state)
         S_LOAD:   if (handshake && ld_last) next_state = S_RSTCYC;
         S_RSTCYC: next_state = cmd_load ? S_LOAD : S_HALT;
         S_HALT: begin
            if (cmd_load)      next_state = S_LOAD;
            else if (cmd_step) next_state = S_STEP;
            else if (cmd_run)  next_state = S_RUN;
         end
         S_STEP:   next_state = cmd_load ? S_LOAD : S_HALT;
         S_RUN: begin
            if (cmd_load)                  next_state = S_LOAD;
            else if (cmd_halt || bp_match) next_state = S_HALT;
         end
         default:  next_state = S_LOAD;
      endcase
   end

   // CPU clock enable: open for the reset cycle and a step, gated same-cycle
   // by the breakpoint comparator while running.
   always_comb begin
      cpu_clk_en = 1'b0;
      unique case (state)
         S_RSTCYC, S_STEP: cpu_clk_en = 1'b1;
         S_RUN:            cpu_clk_en = ~bp_match;
         default:          cpu_clk_en = 1'b0;
      endcase
   end

   // State register, load counter, sticky flags and registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_LOAD;
         ld_cnt      <= '0;
         ld_wrap     <= 1'b0;
         bp_hit      <= 1'b0;
         armed       <= 1'b0;
         ready_q     <= 1'b0;
         cpu_reset_q <= 1'b1;
         halted_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register here samples pre-edge values.
         state       <= next_state;
         ready_q     <= (next_state == S_LOAD);
         cpu_reset_q <= (next_state == S_LOAD) || (next_state == S_RSTCYC);
         halted_q    <= (next_state == S_HALT);
         armed       <= (state == S_RUN);

         if (state == S_LOAD && handshake) begin
            ld_cnt <= ld_cnt + ROM_AW'(1);
            if (&ld_cnt) ld_wrap <= 1'b1;
         end

         if (state == S_RUN && bp_match && !cmd_load) bp_hit <= 1'b1;
         if (state == S_HALT && next_state == S_RUN)  bp_hit <= 1'b0;

         // Abandoning execution restarts the load from address 0 with clean flags
         if (state != S_LOAD && next_state == S_LOAD) begin
            ld_cnt  <= '0;
            ld_wrap <= 1'b0;
            bp_hit  <= 1'b0;
         end
      end
   end

endmodule
